vram_scanout: RTL

Display-side reader of the monochrome line VRAM that the text writers fill. It generates 640x480@60 VGA timing from the pixel clock and, during each horizontal blanking interval, fetches the next 640-bit line from VRAM through the shared `vram_turn` arbitration. Each line is held in a ping-pong line buffer and serialized one pixel per clock to the DAC/pin stage.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/vram_scanout.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, fetch FSM states and line-fetch helpers
// for the VRAM scanout path.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned H_FRONT      = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BACK       = 48;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned V_FRONT      = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BACK       = 33;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned H_W    = 10;
  localparam int unsigned V_W    = 10;
  localparam int unsigned LINE_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // A line needs fetching when the following scanline is visible.
  function automatic logic fetch_has_target(input logic [V_W-1:0] v);
    return (v < V_W'(V_VISIBLE - 1)) || (v == V_W'(V_TOTAL - 1));
  endfunction

  function automatic logic [LINE_W-1:0] fetch_target(input logic [V_W-1:0] v);
    logic [V_W-1:0] nxt;
    nxt = (v == V_W'(V_TOTAL - 1)) ? '0 : v + V_W'(1);
    return LINE_W'(nxt);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with registered sync and visible-region decode.
module vga_timing_gen
  import vga_timing_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] h_count_c,
  output logic [V_W-1:0] v_count_c,
  output logic           visible_c,
  output logic           line_end_c,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on
);

  logic [H_W-1:0] h_count_q, h_count_d;
  logic [V_W-1:0] v_count_q, v_count_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           video_on_q, video_on_d;

  always_comb begin
    h_count_d  = h_count_q + H_W'(1);
    v_count_d  = v_count_q;
    line_end_c = (h_count_q == H_W'(H_TOTAL - 1));
    if (line_end_c) begin
      h_count_d = '0;
      v_count_d = (v_count_q == V_W'(V_TOTAL - 1)) ? '0 : v_count_q + V_W'(1);
    end
    visible_c  = (h_count_q < H_W'(H_VISIBLE)) && (v_count_q < V_W'(V_VISIBLE));
    hsync_d    = !((h_count_q >= H_W'(H_SYNC_START)) && (h_count_q < H_W'(H_SYNC_END)));
    vsync_d    = !((v_count_q >= V_W'(V_SYNC_START)) && (v_count_q < V_W'(V_SYNC_END)));
    video_on_d = visible_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count_q  <= '0;
      v_count_q  <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      h_count_q  <= h_count_d;
      v_count_q  <= v_count_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign h_count_c = h_count_q;
  assign v_count_c = v_count_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;

endmodule

// File: rtl/vram_scanout.sv
// VRAM line fetcher with ping-pong line buffers and one-pixel-per-clock
// serializer, driven by the VGA timing generator.
module vram_scanout
  import vga_timing_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [H_VISIBLE-1:0] line_from_vram,
  input  logic                 vram_turn,
  output logic                 read_req,
  output logic [LINE_W-1:0]    line_addr,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic                 pixel,
  output logic [H_W-1:0]       x_pos,
  output logic [LINE_W-1:0]    y_pos,
  output logic                 underrun
);

  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           visible;
  logic           line_end;

  vga_timing_gen u_timing (
    .clk        (clk),
    .rst        (rst),
    .h_count_c  (h_count),
    .v_count_c  (v_count),
    .visible_c  (visible),
    .line_end_c (line_end),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on)
  );

  fetch_state_e         state_q, state_d;
  logic                 read_req_q, read_req_d;
  logic [LINE_W-1:0]    line_addr_q, line_addr_d;
  logic                 underrun_q, underrun_d;
  logic                 sel_q, sel_d;
  logic                 front_valid_q, front_valid_d;
  logic                 back_valid_q, back_valid_d;
  logic [H_VISIBLE-1:0] buf0_q, buf0_d;
  logic [H_VISIBLE-1:0] buf1_q, buf1_d;
  logic                 pixel_q, pixel_d;

  logic                 has_target;
  logic                 capture;
  logic                 swap;
  logic                 back_valid_nx;
  logic [H_VISIBLE-1:0] front_c;
  logic [H_W-1:0]       pix_idx;

  always_comb begin
    state_d       = state_q;
    read_req_d    = read_req_q;
    line_addr_d   = line_addr_q;
    underrun_d    = underrun_q;
    back_valid_nx = back_valid_q;
    capture       = 1'b0;
    has_target    = fetch_has_target(v_count);

    case (state_q)
      ST_IDLE: begin
        if ((h_count == H_W'(H_VISIBLE)) && has_target) begin
          state_d     = ST_REQ;
          read_req_d  = 1'b1;
          line_addr_d = fetch_target(v_count);
        end
      end
      ST_REQ: begin
        // A grant on the last clock of the window still wins over the abandon.
        if (vram_turn) begin
          capture       = 1'b1;
          back_valid_nx = 1'b1;
          read_req_d    = 1'b0;
          state_d       = line_end ? ST_IDLE : ST_DONE;
        end else if (line_end) begin
          back_valid_nx = 1'b0;
          read_req_d    = 1'b0;
          underrun_d    = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (line_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Swap sees this edge's capture so a last-clock grant is displayed.
    swap          = line_end && has_target;
    sel_d         = swap ? ~sel_q : sel_q;
    front_valid_d = swap ? back_valid_nx : front_valid_q;
    back_valid_d  = swap ? 1'b0 : back_valid_nx;

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (capture) begin
      if (sel_q) buf0_d = line_from_vram;
      else       buf1_d = line_from_vram;
    end

    front_c = sel_q ? buf1_q : buf0_q;
    pix_idx = visible ? h_count : '0;
    pixel_d = front_c[pix_idx] & front_valid_q & visible;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      read_req_q    <= 1'b0;
      line_addr_q   <= '0;
      underrun_q    <= 1'b0;
      sel_q         <= 1'b0;
      front_valid_q <= 1'b0;
      back_valid_q  <= 1'b0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      pixel_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_req_q    <= read_req_d;
      line_addr_q   <= line_addr_d;
      underrun_q    <= underrun_d;
      sel_q         <= sel_d;
      front_valid_q <= front_valid_d;
      back_valid_q  <= back_valid_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      pixel_q       <= pixel_d;
    end
  end

  assign read_req  = read_req_q;
  assign line_addr = line_addr_q;
  assign underrun  = underrun_q;
  assign pixel     = pixel_q;
  assign x_pos     = h_count;
  // Back-porch lines above 511 alias in the 9-bit copy.
  assign y_pos     = LINE_W'(v_count);

endmodule
